// File: rtl/mac_shift_add_sequencer.sv
// Sequential unsigned shift-add multiplier feeding a running accumulator with a
// sticky carry-out flag. One operand pair is accepted at a time on valid/ready.
module mac_shift_add_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 20
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  clear_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ACC_WIDTH-1:0]  acc_o,
  output logic                  ovf_o,
  output logic [2:0]            step_o,
  output logic                  busy_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [2:0] STEP_LAST = 3'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACC, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          a_sh_q, a_sh_d;
  logic [DATA_WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [PW-1:0]          partial_q, partial_d;
  logic [2:0]             step_q, step_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH:0]     acc_sum;

  // Widened add so the carry-out lands in the top bit.
  function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                 input logic [PW-1:0]        p);
    acc_add = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(p);
  endfunction

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      partial_q   <= '0;
      step_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      partial_q   <= partial_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    partial_d   = partial_q;
    step_d      = step_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    acc_sum     = acc_add(acc_q, partial_q);
    case (state_q)
      S_IDLE: begin
        // Clear first so a simultaneous accept accumulates onto zero.
        if (clear_i) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        if (in_valid_i) begin
          a_sh_d    = PW'(a_i);
          b_sh_d    = b_i;
          partial_d = '0;
          step_d    = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (b_sh_q[0]) partial_d = partial_q + a_sh_q;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        if (step_q == STEP_LAST) begin
          step_d  = '0;
          state_d = S_ACC;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_ACC: begin
        acc_d       = acc_sum[ACC_WIDTH-1:0];
        if (acc_sum[ACC_WIDTH]) ovf_d = 1'b1;
        out_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign busy_o      = (state_q == S_RUN) || (state_q == S_ACC);
  assign out_valid_o = out_valid_q;
  assign acc_o       = acc_q;
  assign ovf_o       = ovf_q;
  assign step_o      = step_q;

endmodule

// File: tb/tb_mac_shift_add_sequencer.sv
// Scoreboard bench for mac_shift_add_sequencer: expected accumulator/overflow
// pairs are queued at issue and compared when out_valid_o appears.
module tb_mac_shift_add_sequencer;

  localparam int DW = 8;
  localparam int AW = 20;

  logic          clk_i = 1'b0;
  logic          nreset_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] a_i = '0;
  logic [DW-1:0] b_i = '0;
  logic          clear_i = 1'b0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [AW-1:0] acc_o;
  logic          ovf_o;
  logic [2:0]    step_o;
  logic          busy_o;

  typedef struct {
    logic [AW-1:0] acc;
    logic          ovf;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] model_acc = '0;
  logic          model_ovf = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  mac_shift_add_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .clear_i     (clear_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .acc_o       (acc_o),
    .ovf_o       (ovf_o),
    .step_o      (step_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_issue(input int a, input int b, input bit clr);
    int unsigned s;
    exp_t e;
    if (clr) begin
      model_acc = '0;
      model_ovf = 1'b0;
    end
    s = int'(model_acc) + a * b;
    if (s >= (1 << AW)) model_ovf = 1'b1;
    model_acc = AW'(s);
    e.acc = model_acc;
    e.ovf = model_ovf;
    sb.push_back(e);
  endtask

  // Issue one op; optionally check the step sequence and hold DONE with junk stimulus.
  task automatic do_op(input int a, input int b, input bit clr, input bit chk_steps,
                       input int hold);
    int   n;
    int   lat;
    exp_t e;
    model_issue(a, b, clr);
    a_i = DW'(a); b_i = DW'(b); clear_i = clr; in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 50) begin tick(); n++; end
    n_checks++;
    if (n >= 50) begin n_fail++; $display("FAIL accept_timeout in_ready=%0b required 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0; clear_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 40) begin
      n_checks++;
      if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL in_ready_busy cyc=%0d got %0b required 0", lat, in_ready_o); end
      if (chk_steps && lat < DW) begin
        n_checks++;
        if (step_o !== 3'(lat) || busy_o !== 1'b1) begin
          n_fail++; $display("FAIL step_seq cyc=%0d step=%0d busy=%0b required step=%0d busy=1", lat, step_o, busy_o, lat);
        end
      end
      tick(); lat++;
    end
    n_checks++;
    if (lat != DW + 1) begin n_fail++; $display("FAIL latency got %0d required %0d", lat, DW + 1); end
    e = sb.pop_front();
    n_checks++;
    if (acc_o !== e.acc || ovf_o !== e.ovf || in_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL result a=%0d b=%0d got acc=%0d ovf=%0b rdy=%0b busy=%0b required acc=%0d ovf=%0b rdy=0 busy=0",
                         a, b, acc_o, ovf_o, in_ready_o, busy_o, e.acc, e.ovf);
    end
    for (int i = 0; i < hold; i++) begin
      in_valid_i = 1'b1; clear_i = 1'b1; a_i = DW'(i + 77); b_i = DW'(i + 3);
      tick();
      n_checks++;
      if (acc_o !== e.acc || ovf_o !== e.ovf || out_valid_o !== 1'b1 || in_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL done_hold cyc=%0d got acc=%0d ovf=%0b vld=%0b rdy=%0b required acc=%0d ovf=%0b vld=1 rdy=0",
                           i, acc_o, ovf_o, out_valid_o, in_ready_o, e.acc, e.ovf);
      end
    end
    in_valid_i = 1'b0; clear_i = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    n_checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || acc_o !== e.acc) begin
      n_fail++; $display("FAIL handshake got vld=%0b rdy=%0b acc=%0d required vld=0 rdy=1 acc=%0d", out_valid_o, in_ready_o, acc_o, e.acc);
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    model_acc = '0; model_ovf = 1'b0;
    n_checks++;
    if (acc_o !== '0 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL clear got acc=%0d ovf=%0b required acc=0 ovf=0", acc_o, ovf_o);
    end
  endtask

  task automatic test_reset();
    nreset_i = 1'b0;
    #3;
    n_checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || acc_o !== '0 || ovf_o !== 1'b0 ||
        step_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_state rdy=%0b vld=%0b acc=%0d ovf=%0b step=%0d busy=%0b required 1 0 0 0 0 0",
                         in_ready_o, out_valid_o, acc_o, ovf_o, step_o, busy_o);
    end
    tick(); tick();
    nreset_i = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    do_op(5, 3, 1'b0, 1'b1, 0);
    n_checks++;
    if (acc_o !== 20'd15 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_5x3 got acc=%0d ovf=%0b required acc=15 ovf=0", acc_o, ovf_o);
    end
    do_op(0, 200, 1'b0, 1'b1, 0);
    do_op(173, 0, 1'b0, 1'b0, 0);
    do_op(129, 131, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    do_clear();
    do_op(255, 255, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd65025) begin n_fail++; $display("FAIL b2b_first got %0d required 65025", acc_o); end
    do_op(255, 255, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd130050) begin n_fail++; $display("FAIL b2b_second got %0d required 130050", acc_o); end
  endtask

  task automatic test_overflow();
    do_clear();
    for (int i = 0; i < 16; i++) do_op(255, 255, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd1040400 || ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_16 got acc=%0d ovf=%0b required acc=1040400 ovf=0", acc_o, ovf_o);
    end
    do_op(255, 255, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd56849 || ovf_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_17 got acc=%0d ovf=%0b required acc=56849 ovf=1", acc_o, ovf_o);
    end
    do_op(1, 1, 1'b0, 1'b0, 0);
    n_checks++;
    if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b required 1", ovf_o); end
    do_clear();
  endtask

  task automatic test_done_hold();
    do_op(3, 7, 1'b0, 1'b0, 5);
    do_op(11, 13, 1'b0, 1'b0, 0);
  endtask

  task automatic test_clear_accept_and_reset();
    int n;
    do_clear();
    do_op(10, 10, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd100) begin n_fail++; $display("FAIL preload got %0d required 100", acc_o); end
    do_op(2, 4, 1'b1, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd8) begin n_fail++; $display("FAIL clear_accept got %0d required 8", acc_o); end
    a_i = 8'd9; b_i = 8'd9; in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    n = 0;
    while (step_o !== 3'd4 && n < 20) begin tick(); n++; end
    n_checks++;
    if (n >= 20) begin n_fail++; $display("FAIL step4_timeout step=%0d required 4", step_o); end
    #2;
    nreset_i = 1'b0;
    #1;
    n_checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || acc_o !== '0 || ovf_o !== 1'b0 ||
        step_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL midop_reset rdy=%0b vld=%0b acc=%0d ovf=%0b step=%0d busy=%0b required 1 0 0 0 0 0",
                         in_ready_o, out_valid_o, acc_o, ovf_o, step_o, busy_o);
    end
    model_acc = '0; model_ovf = 1'b0;
    sb.delete();
    tick();
    nreset_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
        n_fail++; $display("FAIL post_reset cyc=%0d vld=%0b rdy=%0b required vld=0 rdy=1", i, out_valid_o, in_ready_o);
      end
    end
    do_op(6, 7, 1'b0, 1'b0, 0);
    n_checks++;
    if (acc_o !== 20'd42) begin n_fail++; $display("FAIL after_reset_op got %0d required 42", acc_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_done_hold();
    test_clear_accept_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
